// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM port-B arbiter: requester ids, FSM states, latency limit.
package ram_arb_pkg;

    localparam int unsigned REQ_DMA    = 0;
    localparam int unsigned REQ_STACK  = 1;
    localparam int unsigned REQ_PRAM   = 2;

    localparam int unsigned RD_LAT_MAX = 4;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [PTR_W-1:0] ptr,
    input  logic [N_REQ-1:0] valid,
    output logic [N_REQ-1:0] grant
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((32'(ptr) + k) % N_REQ);
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin sharing of RAM port B among DMA data, DMA stack and PRAM copy requesters.
// Optional grant locking is built when RAM_ARB_LOCK_EN is defined.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned N_REQ    = 3,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic                      physical_clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ-1:0]          req_abs,
    input  logic [N_REQ-1:0]          req_lock,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    input  logic [ADDR_W-1:0]         base_k,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    output logic                      ram_we,
    input  logic [DATA_W-1:0]         ram_rdata,
    output logic                      busy
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX || N_REQ <= REQ_PRAM || REQ_STACK == REQ_DMA) begin : g_bad_cfg
        $error("ram_port_arbiter: unsupported RD_LAT or N_REQ");
    end

    arb_state_e                  state_q, state_d;
    logic [PTR_W-1:0]            ptr_q, ptr_d, ptr_inc;
    logic [N_REQ-1:0]            valid_eff, grant;
    logic                        beat;
    logic [PTR_W-1:0]            g_idx;
    logic                        g_we, g_abs;
    logic [ADDR_W-1:0]           g_addr;
    logic [DATA_W-1:0]           g_wdata;
    logic [RD_LAT:0][N_REQ-1:0]  tags_q;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .ptr   (ptr_q),
        .valid (valid_eff),
        .grant (grant)
    );

    assign req_ready = grant;
    assign beat      = |grant;

    always_comb begin
        g_idx   = '0;
        g_we    = 1'b0;
        g_abs   = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                g_idx   = PTR_W'(i);
                g_we    = req_we[i];
                g_abs   = req_abs[i];
                g_addr  = req_addr[i*ADDR_W +: ADDR_W];
                g_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_inc = (g_idx == PTR_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;

`ifdef RAM_ARB_LOCK_EN
    localparam int unsigned LCNT_W = $clog2(MAX_LOCK + 1);

    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              g_lock;

    always_comb begin
        g_lock = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) g_lock = req_lock[i];
        end
    end

    // While locked, everyone but the owner is masked before arbitration.
    assign valid_eff = (state_q == LOCKED) ? (req_valid & (N_REQ'(1) << owner_q)) : req_valid;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            ARB: begin
                if (beat) begin
                    ptr_d = ptr_inc;
                    if (g_lock && MAX_LOCK > 1) begin
                        state_d = LOCKED;
                        owner_d = g_idx;
                        lcnt_d  = LCNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (beat) begin
                    if (!g_lock || lcnt_q == LCNT_W'(MAX_LOCK - 1)) begin
                        state_d = ARB;
                        ptr_d   = ptr_inc;
                    end else begin
                        lcnt_d = lcnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge physical_clock) begin
        if (reset) begin
            owner_q <= '0;
            lcnt_q  <= '0;
        end else begin
            owner_q <= owner_d;
            lcnt_q  <= lcnt_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock ^ (MAX_LOCK != 0);
    assign valid_eff   = req_valid;

    always_comb begin
        state_d = ARB;
        ptr_d   = ptr_q;
        if (beat) ptr_d = ptr_inc;
    end
`endif

    always_ff @(posedge physical_clock) begin
        if (reset) begin
            state_q   <= ARB;
            ptr_q     <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
            tags_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (beat) begin
                ram_addr  <= g_abs ? g_addr : g_addr + base_k;
                ram_we    <= g_we;
                ram_wdata <= g_we ? g_wdata : '0;
            end else begin
                ram_we <= 1'b0;
            end
            // Stage RD_LAT lines up with ram_rdata for the read issued RD_LAT+1 cycles earlier.
            tags_q[0] <= (beat && !g_we) ? grant : '0;
            for (int unsigned s = 1; s <= RD_LAT; s++) begin
                tags_q[s] <= tags_q[s-1];
            end
        end
    end

    assign rsp_valid = tags_q[RD_LAT];
    assign rsp_rdata = (|rsp_valid) ? ram_rdata : '0;
    assign busy      = (|tags_q) | (state_q == LOCKED);

endmodule
